mem_ctrl_fsm: RTL and testbench

MEM_CTRL_FSM -- requirements
Module: mem_ctrl_fsm

---
 rtl/mem_ctrl_fsm_pkg.sv | 15 +
 rtl/mem_ctrl_fsm_if.sv | 30 +++
 rtl/mem_array.sv | 34 +++
 rtl/mem_ctrl_fsm.sv | 105 ++++++++++
 tb/tb_mem_ctrl_fsm.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_fsm_pkg.sv
// Shared types and default geometry for the memory controller FSM.
// Imported by the bus interface, the storage array and the controller.
package mem_ctrl_fsm_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ctrl_fsm_if.sv
// Request/response bundle between a requester (master) and mem_ctrl_fsm (slave).
// Clock and reset stay plain ports on the modules.
interface mem_ctrl_fsm_if
  import mem_ctrl_fsm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              r;
  logic              w;
  logic              clr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;
  logic              err;

  modport master (
    output r, w, clr, addr, din,
    input  dout, dout_valid, busy, err
  );

  modport slave (
    input  r, w, clr, addr, din,
    output dout, dout_valid, busy, err
  );

endinterface

// File: rtl/mem_array.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous
// read port, every word cleared by the asynchronous reset.
module mem_array
  import mem_ctrl_fsm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the words are reset on purpose: an aborted write or clear must
  // leave no data behind, so this stays flops rather than an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_ctrl_fsm.sv
// Single-port memory controller: IDLE/WRITE/READ/CLEAR FSM, request latches,
// clear counter and registered read outputs around a mem_array.
module mem_ctrl_fsm
  import mem_ctrl_fsm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic           clk,
  input logic           rst_n,
  mem_ctrl_fsm_if.slave bus
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [ADDR_W-1:0] cnt;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  // NOTE: every output of this block gets a default before the case so no
  // state leaves a signal unassigned and no latch is inferred.
  always_comb begin
    we    = 1'b0;
    waddr = addr_q;
    wdata = din_q;
    case (state)
      ST_WRITE: we = 1'b1;
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
        wdata = '0;
      end
      default: ;
    endcase
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addr_q),
    .rdata (rdata)
  );

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      addr_q         <= '0;
      din_q          <= '0;
      cnt            <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.dout_valid <= 1'b0;
      bus.err        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.clr) begin
            cnt   <= '0;
            state <= ST_CLEAR;
          end else if (bus.r && bus.w) begin
            bus.err <= 1'b1;
          end else if (bus.w) begin
            addr_q <= bus.addr;
            din_q  <= bus.din;
            state  <= ST_WRITE;
          end else if (bus.r) begin
            addr_q <= bus.addr;
            state  <= ST_READ;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        ST_READ: begin
          bus.dout       <= rdata;
          bus.dout_valid <= 1'b1;
          state          <= ST_IDLE;
        end
        ST_CLEAR: begin
          // Counter saturates at the last word; leaving CLEAR ends the sweep.
          if (cnt == LAST_ADDR) state <= ST_IDLE;
          else                  cnt   <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Scoreboard bench for mem_ctrl_fsm: an 8x8 instance for the main scenarios
// and a 16x16 instance for the wide-geometry case.
module tb_mem_ctrl_fsm;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] model_a[8];

  mem_ctrl_fsm_if #(.DATA_W(8),  .ADDR_W(3)) a_if ();
  mem_ctrl_fsm_if #(.DATA_W(16), .ADDR_W(4)) b_if ();

  mem_ctrl_fsm #(.DATA_W(8),  .ADDR_W(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  mem_ctrl_fsm #(.DATA_W(16), .ADDR_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Read completions are compared against the queued expectation, including the cycle.
  always @(negedge clk) begin
    exp_t e;
    if (a_if.dout_valid && a_if.err) check("a_err_with_valid", 1, 0);
    if (a_if.dout_valid) begin
      if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        e = q_a.pop_front();
        check("a_rd_data", 32'(a_if.dout), e.data);
        check("a_rd_cycle", cyc, e.due);
      end
    end
    if (b_if.dout_valid) begin
      if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        e = q_b.pop_front();
        check("b_rd_data", 32'(b_if.dout), e.data);
        check("b_rd_cycle", cyc, e.due);
      end
    end
  end

  task automatic drive_a(input logic r, input logic w, input logic c,
                         input logic [2:0] a, input logic [7:0] d);
    a_if.r = r; a_if.w = w; a_if.clr = c; a_if.addr = a; a_if.din = d;
    @(posedge clk); #1;
    a_if.r = 1'b0; a_if.w = 1'b0; a_if.clr = 1'b0;
  endtask

  task automatic write_a(input logic [2:0] a, input logic [7:0] d);
    model_a[a] = d;
    drive_a(1'b0, 1'b1, 1'b0, a, d);
    @(posedge clk); #1;
  endtask

  task automatic read_a(input logic [2:0] a);
    q_a.push_back(exp_t'{32'(model_a[a]), cyc + 2});
    drive_a(1'b1, 1'b0, 1'b0, a, 8'h00);
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input logic r, input logic w, input logic c,
                         input logic [3:0] a, input logic [15:0] d);
    b_if.r = r; b_if.w = w; b_if.clr = c; b_if.addr = a; b_if.din = d;
    @(posedge clk); #1;
    b_if.r = 1'b0; b_if.w = 1'b0; b_if.clr = 1'b0;
  endtask

  task automatic count_busy_a(input string tag, input int exp);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_if.busy) n++;
      else break;
    end
    check(tag, n, exp);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
    #1;
    check(tag, q_a.size() + q_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.r = 1'b0; a_if.w = 1'b0; a_if.clr = 1'b0; a_if.addr = '0; a_if.din = '0;
    b_if.r = 1'b0; b_if.w = 1'b0; b_if.clr = 1'b0; b_if.addr = '0; b_if.din = '0;
    for (int i = 0; i < 8; i++) model_a[i] = 8'h00;

    #1 rst_n = 1'b0;
    #1;
    check("rst_dout",  32'(a_if.dout), 0);
    check("rst_valid", 32'(a_if.dout_valid), 0);
    check("rst_err",   32'(a_if.err), 0);
    check("rst_busy",  32'(a_if.busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // First request right after reset release is accepted on the next edge.
    read_a(3'd0);

    // Basic write/write/read/read.
    write_a(3'd0, 8'd73);
    write_a(3'd1, 8'd97);
    read_a(3'd0);
    read_a(3'd1);

    // Read on the first idle cycle after a write sees the new data.
    write_a(3'd4, 8'h3C);
    read_a(3'd4);

    // Illegal R&W: single ERR pulse, never busy, no memory access.
    drive_a(1'b1, 1'b1, 1'b0, 3'd2, 8'h55);
    @(negedge clk);
    check("err_pulse", 32'(a_if.err), 1);
    check("err_busy",  32'(a_if.busy), 0);
    @(negedge clk);
    check("err_once",  32'(a_if.err), 0);
    read_a(3'd2);

    // W during READ is dropped, not queued.
    q_a.push_back(exp_t'{32'(model_a[3]), cyc + 2});
    drive_a(1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
    drive_a(1'b0, 1'b1, 1'b0, 3'd3, 8'h11);
    @(negedge clk);
    check("busy_w_ignored", 32'(a_if.busy), 0);
    read_a(3'd3);

    for (int i = 0; i < 6; i++) begin
      write_a(3'($urandom_range(0, 7)), 8'($urandom));
      read_a(3'($urandom_range(0, 7)));
    end

    // Reset in the middle of a write: nothing is committed, DOUT forced low.
    write_a(3'd6, 8'hC3);
    read_a(3'd6);
    repeat (2) @(posedge clk);
    drive_a(1'b0, 1'b1, 1'b0, 3'd5, 8'hAA);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) model_a[i] = 8'h00;
    #1;
    check("midwr_rst_dout",  32'(a_if.dout), 0);
    check("midwr_rst_busy",  32'(a_if.busy), 0);
    check("midwr_rst_valid", 32'(a_if.dout_valid), 0);
    repeat (2) begin
      @(negedge clk);
      check("midwr_hold_dout", 32'(a_if.dout), 0);
    end
    rst_n = 1'b1;
    read_a(3'd5);
    read_a(3'd6);

    // Fill with 0xFF, then clear: BUSY for exactly DEPTH cycles.
    for (int i = 0; i < 8; i++) write_a(3'(i), 8'hFF);
    read_a(3'd7);
    drive_a(1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    for (int i = 0; i < 8; i++) model_a[i] = 8'h00;
    count_busy_a("clr_busy_cycles", 8);
    for (int i = 0; i < 8; i++) read_a(3'(i));
    drain("a_sb_empty");

    // Wide geometry instance.
    drive_b(1'b0, 1'b1, 1'b0, 4'd15, 16'hBEEF);
    @(posedge clk); #1;
    q_b.push_back(exp_t'{32'h0000BEEF, cyc + 2});
    drive_b(1'b1, 1'b0, 1'b0, 4'd15, 16'h0000);
    @(posedge clk); #1;
    drive_b(1'b0, 1'b0, 1'b1, 4'd0, 16'h0000);
    begin
      int n = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (b_if.busy) n++;
        else break;
      end
      check("b_clr_busy_cycles", n, 16);
    end
    q_b.push_back(exp_t'{32'h0, cyc + 2});
    drive_b(1'b1, 1'b0, 1'b0, 4'd15, 16'h0000);
    @(posedge clk); #1;
    drain("b_sb_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
